// File: rtl/data_sram_responder_pkg.sv
// Shared constants for the data SRAM responder: access-size encoding, LFSR seed/taps
// for the optional random-delay mode, and the per-entry age counter width.
package data_sram_responder_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR sit at bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Wide enough for LATENCY (max 15) plus the random extra delay (max 3).
    localparam int AGE_W = 5;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/data_sram_responder_resp_fifo.sv
// In-order response queue: circular FIFO whose entries carry data, an age counter and
// a target latency; the head pops on the cycle its age reaches its target.
module resp_fifo
    import data_sram_responder_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int DW     = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [DW-1:0]    push_data,
    input  logic [AGE_W-1:0] push_lat,
    output logic             not_full,
    output logic             ready,
    output logic [DW-1:0]    head_data
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]    count_reg;
    logic [PW-1:0]    head_reg;
    logic [PW-1:0]    tail_reg;
    logic [DW-1:0]    data_reg [QDEPTH];
    logic [AGE_W-1:0] age_reg  [QDEPTH];
    logic [AGE_W-1:0] lat_reg  [QDEPTH];
    logic             do_push;

    // Full blocks a push even when the head pops this cycle.
    assign not_full  = (count_reg < CW'(QDEPTH));
    assign do_push   = push && not_full;
    assign ready     = (count_reg != '0) && (age_reg[head_reg] == lat_reg[head_reg]);
    assign head_data = ready ? data_reg[head_reg] : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
        end else begin
            if (do_push) tail_reg <= tail_reg + 1'b1;
            if (ready)   head_reg <= head_reg + 1'b1;
            if (do_push && !ready)      count_reg <= count_reg + 1'b1;
            else if (!do_push && ready) count_reg <= count_reg - 1'b1;
        end
    end

    // Entry payloads are never reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (do_push && tail_reg == PW'(i)) begin
                data_reg[i] <= push_data;
                age_reg[i]  <= AGE_W'(1);
                lat_reg[i]  <= push_lat;
            end else if (age_reg[i] < lat_reg[i]) begin
                age_reg[i] <= age_reg[i] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// SRAM-like data-memory responder with byte-strobed word array and in-order fixed-latency
// responses. Define DATA_SRAM_RANDOM_DELAY_EN for LFSR-driven accept gating and extra latency.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int AW_WORD = 12,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);
    logic [31:0]        mem_reg [2**AW_WORD];
    logic [AW_WORD-1:0] word_idx;
    logic [31:0]        cur_word;
    logic [31:0]        merged_word;
    logic [31:0]        push_data;
    logic [AGE_W-1:0]   push_lat;
    logic               accept;
    logic               fifo_not_full;
    logic               unused_bits;

    // Upper address bits alias; size is informational only.
    assign word_idx    = data_sram_addr[AW_WORD+1:2];
    assign unused_bits = ^{data_sram_size, data_sram_addr[31:AW_WORD+2], data_sram_addr[1:0]};
    assign cur_word    = mem_reg[word_idx];
    assign accept      = data_sram_req && data_sram_addr_ok;
    assign push_data   = data_sram_wr ? 32'd0 : cur_word;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[gi*8 +: 8] = data_sram_wstrb[gi] ? data_sram_wdata[gi*8 +: 8]
                                                                : cur_word[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) mem_reg[word_idx] <= merged_word;
    end

`ifdef DATA_SRAM_RANDOM_DELAY_EN
    logic [15:0] lfsr_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_reg <= LFSR_SEED;
        else         lfsr_reg <= lfsr_next(lfsr_reg);
    end

    assign data_sram_addr_ok = fifo_not_full && lfsr_reg[0];
    assign push_lat          = AGE_W'(LATENCY) + AGE_W'(lfsr_reg[2:1]);
`else
    assign data_sram_addr_ok = fifo_not_full;
    assign push_lat          = AGE_W'(LATENCY);
`endif

    resp_fifo #(
        .QDEPTH (QDEPTH),
        .DW     (32)
    ) u_resp_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (accept),
        .push_data (push_data),
        .push_lat  (push_lat),
        .not_full  (fifo_not_full),
        .ready     (data_sram_data_ok),
        .head_data (data_sram_rdata)
    );

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench: a LATENCY=2 instance driven by directed and random traffic, plus a
// LATENCY=8 instance for the full/backpressure and reset-drop behaviour.
module tb_data_sram_responder;
    localparam int LAT = 2;
    localparam int QD  = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd2;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    logic        req8 = 1'b0;
    logic        addr_ok8, data_ok8;
    logic [31:0] rdata8;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [4096];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_sram_responder #(.AW_WORD(12), .LATENCY(LAT), .QDEPTH(QD)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .data_sram_req     (req),
        .data_sram_wr      (wr),
        .data_sram_size    (size),
        .data_sram_addr    (addr),
        .data_sram_wstrb   (wstrb),
        .data_sram_wdata   (wdata),
        .data_sram_addr_ok (addr_ok),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata)
    );

    data_sram_responder #(.AW_WORD(12), .LATENCY(8), .QDEPTH(4)) dut8 (
        .clk               (clk),
        .resetn            (resetn),
        .data_sram_req     (req8),
        .data_sram_wr      (1'b0),
        .data_sram_size    (2'd2),
        .data_sram_addr    (32'h40),
        .data_sram_wstrb   (4'h0),
        .data_sram_wdata   (32'h0),
        .data_sram_addr_ok (addr_ok8),
        .data_sram_data_ok (data_ok8),
        .data_sram_rdata   (rdata8)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor/scoreboard: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t        e;
        logic        exp_ok;
        logic [11:0] idx;
        if (!resetn) begin
            sb.delete();
            check_eq("rst_addr_ok", {31'd0, addr_ok}, 32'd1);
            check_eq("rst_data_ok", {31'd0, data_ok}, 32'd0);
            check_eq("rst_rdata", rdata, 32'd0);
        end else begin
            exp_ok = (sb.size() > 0) && (sb[0].due == cyc);
            check_eq("addr_ok", {31'd0, addr_ok}, {31'd0, sb.size() < QD});
            if (data_ok || exp_ok) begin
                check_eq("data_ok", {31'd0, data_ok}, {31'd0, exp_ok});
                if (exp_ok) begin
                    e = sb.pop_front();
                    check_eq("rdata", rdata, e.data);
                    $display("rsp cyc=%0d data_ok=%0b rdata=%h exp=%h", cyc, data_ok, rdata, e.data);
                end
            end else begin
                check_eq("idle_rdata", rdata, 32'd0);
            end
            if (req && addr_ok) begin
                idx = addr[13:2];
                if (wr) begin
                    e.data = 32'd0;
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) model_mem[idx][b*8 +: 8] = wdata[b*8 +: 8];
                end else begin
                    e.data = model_mem[idx];
                end
                e.due = cyc + LAT;
                sb.push_back(e);
            end
        end
    end

    task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int t;
        req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
        for (t = 0; t < 64; t++) begin
            @(negedge clk);
            if (addr_ok) break;
        end
        if (t == 64) check_eq("accept_wait", {31'd0, addr_ok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check_eq("post_rst_addr_ok", {31'd0, addr_ok}, 32'd1);
        check_eq("post_rst_data_ok", {31'd0, data_ok}, 32'd0);
        check_eq("post_rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;

        // Full-word write then read back.
        do_req(1'b1, 32'h10, 4'hF, 32'h1122_3344);
        do_req(1'b0, 32'h10, 4'h0, 32'h0);
        idle(4);

        // Partial strobes merge into the existing word.
        do_req(1'b1, 32'h10, 4'hF, 32'h1122_3344);
        do_req(1'b1, 32'h10, 4'b0101, 32'hAABB_CCDD);
        do_req(1'b0, 32'h10, 4'h0, 32'h0);
        idle(4);

        // Zero strobe still responds and leaves memory untouched.
        do_req(1'b1, 32'h20, 4'hF, 32'hCAFE_BABE);
        do_req(1'b1, 32'h20, 4'h0, 32'hDEAD_BEEF);
        do_req(1'b0, 32'h20, 4'h0, 32'h0);
        idle(3);

        // Upper address bits alias onto the same word.
        do_req(1'b1, 32'h0000_4030, 4'hF, 32'h55AA_55AA);
        do_req(1'b0, 32'h0000_0030, 4'h0, 32'h0);
        idle(3);

        // Back-to-back reads with req held.
        do_req(1'b0, 32'h10, 4'h0, 32'h0);
        do_req(1'b0, 32'h20, 4'h0, 32'h0);
        do_req(1'b0, 32'h30, 4'h0, 32'h0);
        do_req(1'b0, 32'h10, 4'h0, 32'h0);
        idle(4);

        // Random traffic over a pre-written window.
        for (int i = 0; i < 16; i++) do_req(1'b1, 32'h100 + 32'(i * 4), 4'hF, $urandom);
        for (int i = 0; i < 60; i++) begin
            do_req(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 15) * 4),
                   4'($urandom), $urandom);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end
        idle(4);

        // Reset with responses in flight drops them; memory survives.
        do_req(1'b0, 32'h10, 4'h0, 32'h0);
        do_req(1'b0, 32'h20, 4'h0, 32'h0);
        do_req(1'b0, 32'h30, 4'h0, 32'h0);
        req = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        idle(8);
        do_req(1'b0, 32'h10, 4'h0, 32'h0);
        idle(4);

        // LATENCY=8 instance: addr_ok drops after 4 accepts, returns after the first data_ok.
        req8 = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            check_eq($sformatf("l8_addr_ok[%0d]", n), {31'd0, addr_ok8}, {31'd0, (n < 4) || (n >= 9)});
            check_eq($sformatf("l8_data_ok[%0d]", n), {31'd0, data_ok8}, {31'd0, (n >= 8) && (n <= 11)});
            $display("l8 n=%0d addr_ok=%0b data_ok=%0b", n, addr_ok8, data_ok8);
        end
        @(posedge clk); #1;
        req8 = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check_eq("l8_post_rst_data_ok", {31'd0, data_ok8}, 32'd0);
            check_eq("l8_post_rst_rdata", rdata8, 32'd0);
        end
        @(posedge clk); #1;

        idle(10);
        check_eq("sb_drain", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
